dff_shreg_param: RTL and testbench

DFF_SHREG_PARAM -- requirements
Module: dff_shreg_param

---
 rtl/dff_shreg_param.sv | 155 +++++++++++++++
 tb/tb_dff_shreg_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_shreg_param.sv
// dff_shreg_param
//   Parameterised word-wide shift register with hold, serial shift, parallel
//   load and synchronous clear. It tracks how many stages hold valid data and
//   flags each valid word that falls off the far end.
//
//   The active clock edge is chosen at elaboration time by NEG_EDGE. Only the
//   sensitivity of the state register changes. There is no clock inversion,
//   gating or derived clock.
//
// Parameters
//   WIDTH    bits per stage (>= 1)
//   DEPTH    number of stages (>= 2)
//   NEG_EDGE 1 = update on falling clk edge, 0 = rising
//   RST_VAL  value loaded into every stage on reset or clear
//
// Ports
//   clk      in   1            clock, active edge per NEG_EDGE
//   rst_n    in   1            asynchronous active-low reset
//   en       in   1            update enable, 0 = hold everything
//   mode     in   2            00 hold, 01 shift, 10 parallel load, 11 clear
//   sin      in   WIDTH        serial word entering stage 0
//   pin      in   DEPTH*WIDTH  parallel data, stage i = pin[i*WIDTH +: WIDTH]
//   sout     out  WIDTH        contents of stage DEPTH-1
//   pout     out  DEPTH*WIDTH  all stages, same packing as pin
//   sout_vld out  1            a valid word was shifted out on the last edge
//   count    out  clog2(DEPTH+1) number of valid stages
//   full     out  1            count == DEPTH
//   empty    out  1            count == 0
module dff_shreg_param #(
  parameter int              WIDTH    = 8,
  parameter int              DEPTH    = 4,
  parameter int              NEG_EDGE = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             sin,
  input  logic [DEPTH*WIDTH-1:0]       pin,
  output logic [WIDTH-1:0]             sout,
  output logic [DEPTH*WIDTH-1:0]       pout,
  output logic                         sout_vld,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] shreg_q [DEPTH];
  logic [WIDTH-1:0] shreg_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             vld_q;
  logic             vld_d;

  // Occupancy grows by one per shift but sticks at DEPTH. Once every stage
  // holds real data, each further shift only swaps one valid word for another.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      return c;
    end
    return c + CNT_W'(1);
  endfunction

  // Next-state logic. sout_vld is a one-edge pulse, so it defaults to 0 and is
  // raised only by a shift that pushes out a word from a full register.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: begin
          shreg_d = shreg_q;
        end
        MODE_SHIFT: begin
          shreg_d[0] = sin;
          for (int i = 1; i < DEPTH; i++) begin
            shreg_d[i] = shreg_q[i-1];
          end
          cnt_d = sat_inc(cnt_q);
          vld_d = (cnt_q == CNT_MAX);
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            shreg_d[i] = pin[i*WIDTH +: WIDTH];
          end
          cnt_d = CNT_MAX;
        end
        MODE_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) begin
            shreg_d[i] = RST_VAL;
          end
          cnt_d = '0;
        end
        default: begin
          shreg_d = shreg_q;
        end
      endcase
    end
  end

  // ---- state register: falling or rising edge, chosen at elaboration ----
  if (NEG_EDGE != 0) begin : g_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          shreg_q[i] <= RST_VAL;
        end
        cnt_q <= '0;
        vld_q <= 1'b0;
      end else begin
        shreg_q <= shreg_d;
        cnt_q   <= cnt_d;
        vld_q   <= vld_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          shreg_q[i] <= RST_VAL;
        end
        cnt_q <= '0;
        vld_q <= 1'b0;
      end else begin
        shreg_q <= shreg_d;
        cnt_q   <= cnt_d;
        vld_q   <= vld_d;
      end
    end
  end

  // ---- outputs: straight from the registers, flags decoded from count ----
  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign pout[g*WIDTH +: WIDTH] = shreg_q[g];
  end

  assign sout     = shreg_q[DEPTH-1];
  assign sout_vld = vld_q;
  assign count    = cnt_q;
  assign full     = (cnt_q == CNT_MAX);
  assign empty    = (cnt_q == '0);

endmodule

// File: tb/tb_dff_shreg_param.sv
// Bench for dff_shreg_param. One instance updates on the falling edge and one
// on the rising edge. Both share the same inputs. A word-queue model per
// instance is stepped on that instance's active edge and compared every half
// cycle. Literal expectations pin the model at key points.
module tb_dff_shreg_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  sin = '0;
  logic [D*W-1:0] pin = '0;
  bit            go = 1'b0;

  // index 0: falling-edge instance, RST_VAL 00; index 1: rising-edge, RST_VAL 5A
  logic [W-1:0]   sout_n, sout_p;
  logic [D*W-1:0] pout_n, pout_p;
  logic           vld_n, vld_p, full_n, full_p, empty_n, empty_p;
  logic [CW-1:0]  cnt_n, cnt_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dff_shreg_param #(.WIDTH(W), .DEPTH(D), .NEG_EDGE(1), .RST_VAL(8'h00)) u_neg (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .pin(pin),
    .sout(sout_n), .pout(pout_n), .sout_vld(vld_n), .count(cnt_n),
    .full(full_n), .empty(empty_n));

  dff_shreg_param #(.WIDTH(W), .DEPTH(D), .NEG_EDGE(0), .RST_VAL(8'h5A)) u_pos (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .pin(pin),
    .sout(sout_p), .pout(pout_p), .sout_vld(vld_p), .count(cnt_p),
    .full(full_p), .empty(empty_p));

  // Model: each instance is a list of D words (index 0 = newest) plus an
  // occupancy number and the "valid word left" flag of the last edge.
  logic [W-1:0] m_q   [2][$];
  int           m_cnt [2];
  bit           m_vld [2];
  logic [W-1:0] m_rv  [2] = '{8'h00, 8'h5A};

  task automatic m_reset(input int k);
    m_q[k].delete();
    for (int i = 0; i < D; i++) m_q[k].push_back(m_rv[k]);
    m_cnt[k] = 0;
    m_vld[k] = 1'b0;
  endtask

  task automatic m_edge(input int k);
    if (!rst_n) begin
      m_reset(k);
    end else begin
      m_vld[k] = 1'b0;
      if (en) begin
        case (mode)
          2'b01: begin
            m_vld[k] = (m_cnt[k] == D);
            m_q[k].push_front(sin);
            void'(m_q[k].pop_back());
            m_cnt[k] = (m_cnt[k] < D) ? m_cnt[k] + 1 : D;
          end
          2'b10: begin
            m_q[k].delete();
            for (int i = 0; i < D; i++) m_q[k].push_back(pin[i*W +: W]);
            m_cnt[k] = D;
          end
          2'b11: m_reset(k);
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    m_reset(0);
    m_reset(1);
  end
  always @(negedge clk) m_edge(0);
  always @(posedge clk) m_edge(1);
  always @(negedge rst_n) begin
    m_reset(0);
    m_reset(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int k, input logic [D*W-1:0] po,
                           input logic [W-1:0] so, input logic v, input logic [CW-1:0] c,
                           input logic f, input logic e);
    logic [D*W-1:0] exp_po;
    for (int i = 0; i < D; i++) exp_po[i*W +: W] = m_q[k][i];
    chk({tag, "_pout"}, 32'(po), 32'(exp_po));
    chk({tag, "_sout"}, 32'(so), 32'(m_q[k][D-1]));
    chk({tag, "_vld"}, 32'(v), 32'(m_vld[k]));
    chk({tag, "_count"}, 32'(c), 32'(m_cnt[k]));
    chk({tag, "_full"}, 32'(f), 32'(m_cnt[k] == D));
    chk({tag, "_empty"}, 32'(e), 32'(m_cnt[k] == 0));
  endtask

  // Compare process: 3 time units after every clock edge.
  always @(posedge clk or negedge clk) begin
    if (go) begin
      #3;
      check_dut("neg", 0, pout_n, sout_n, vld_n, cnt_n, full_n, empty_n);
      check_dut("pos", 1, pout_p, sout_p, vld_p, cnt_p, full_p, empty_p);
    end
  end

  // Drive at falling edge + 1. Both instances then see the inputs on the next
  // rising and falling edges. Return at the following falling edge + 1.
  task automatic apply(input logic e, input logic [1:0] m, input logic [W-1:0] s,
                       input logic [D*W-1:0] p);
    en = e; mode = m; sin = s; pin = p;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    go = 1'b1;
    chk("rst_pout_n", pout_n, 32'h0000_0000);
    chk("rst_pout_p", pout_p, 32'h5A5A_5A5A);
    chk("rst_empty_n", 32'(empty_n), 32'd1);
    chk("rst_full_p", 32'(full_p), 32'd0);

    // Fill. The first word is checked half way through to show the edge split.
    en = 1'b1; mode = 2'b01; sin = 8'h11;
    @(posedge clk); #1;
    chk("edge_cnt_p_after_rise", 32'(cnt_p), 32'd1);
    chk("edge_cnt_n_after_rise", 32'(cnt_n), 32'd0);
    @(negedge clk); #1;
    chk("edge_cnt_n_after_fall", 32'(cnt_n), 32'd1);
    apply(1'b1, 2'b01, 8'h22, '0);
    chk("fill_cnt2", 32'(cnt_n), 32'd2);
    apply(1'b1, 2'b01, 8'h33, '0);
    chk("fill_cnt3", 32'(cnt_n), 32'd3);
    chk("fill_vld3", 32'(vld_n), 32'd0);
    apply(1'b1, 2'b01, 8'h44, '0);
    chk("fill_cnt4", 32'(cnt_n), 32'd4);
    chk("fill_full", 32'(full_n), 32'd1);
    chk("fill_sout", 32'(sout_n), 32'h11);
    chk("fill_vld4", 32'(vld_n), 32'd0);
    chk("fill_pout", pout_n, 32'h1122_3344);

    // Overflow
    apply(1'b1, 2'b01, 8'h55, '0);
    chk("ovf_sout", 32'(sout_n), 32'h22);
    chk("ovf_vld", 32'(vld_n), 32'd1);
    chk("ovf_cnt", 32'(cnt_n), 32'd4);
    apply(1'b1, 2'b00, 8'h66, '0);
    chk("hold_vld", 32'(vld_n), 32'd0);

    // Load, then clear
    apply(1'b1, 2'b10, 8'h00, 32'h4433_2211);
    chk("load_pout", pout_n, 32'h4433_2211);
    chk("load_cnt", 32'(cnt_n), 32'd4);
    chk("load_sout", 32'(sout_n), 32'h44);
    apply(1'b1, 2'b11, 8'h00, 32'hFFFF_FFFF);
    chk("clr_pout_n", pout_n, 32'h0000_0000);
    chk("clr_pout_p", pout_p, 32'h5A5A_5A5A);
    chk("clr_cnt", 32'(cnt_n), 32'd0);
    chk("clr_vld", 32'(vld_n), 32'd0);

    // Hold with en=0 while mode=shift
    apply(1'b1, 2'b01, 8'hAA, '0);
    apply(1'b1, 2'b01, 8'hBB, '0);
    for (int i = 0; i < 3; i++) apply(1'b0, 2'b01, 8'hCC, '0);
    chk("en0_pout", pout_n, 32'h0000_AABB);
    chk("en0_cnt", 32'(cnt_n), 32'd2);

    // Shifts interleaved with holds keep word order
    apply(1'b1, 2'b01, 8'hCC, '0);
    apply(1'b1, 2'b00, 8'h99, '0);
    apply(1'b1, 2'b01, 8'hDD, '0);
    apply(1'b0, 2'b01, 8'h98, '0);
    chk("ilv_sout_aa", 32'(sout_n), 32'hAA);
    chk("ilv_vld0", 32'(vld_n), 32'd0);
    apply(1'b1, 2'b01, 8'hEE, '0);
    chk("ilv_sout_bb", 32'(sout_n), 32'hBB);
    chk("ilv_vld1", 32'(vld_n), 32'd1);

    // Asynchronous reset between edges discards everything
    #1 rst_n = 1'b0;
    #2;
    chk("arst_pout_n", pout_n, 32'h0000_0000);
    chk("arst_pout_p", pout_p, 32'h5A5A_5A5A);
    chk("arst_cnt", 32'(cnt_n), 32'd0);
    chk("arst_empty", 32'(empty_n), 32'd1);
    chk("arst_full", 32'(full_n), 32'd0);
    @(negedge clk); #1;
    apply(1'b1, 2'b01, 8'h77, '0);
    chk("rst_hold_cnt", 32'(cnt_n), 32'd0);
    rst_n = 1'b1;
    apply(1'b1, 2'b01, 8'h01, '0);
    apply(1'b1, 2'b01, 8'h02, '0);
    apply(1'b1, 2'b01, 8'h03, '0);
    apply(1'b1, 2'b01, 8'h04, '0);
    chk("post_rst_sout", 32'(sout_n), 32'h01);
    chk("post_rst_cnt", 32'(cnt_n), 32'd4);
    chk("post_rst_vld", 32'(vld_n), 32'd0);
    apply(1'b0, 2'b00, 8'h00, '0);

    go = 1'b0;
    #10;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
